// File: rtl/vga_sprite_engine.sv
// VGA timing generator with one bouncing, animated, scaled sprite over a solid background.
// Optional macro SPRITE_MIRROR_EN flips the sprite horizontally while it travels left.
module vga_sprite_engine #(
    parameter int          H_PIXELS      = 640,
    parameter int          H_FRONT_PORCH = 16,
    parameter int          H_SYNC_PULSE  = 96,
    parameter int          H_BACK_PORCH  = 48,
    parameter int          V_PIXELS      = 480,
    parameter int          V_FRONT_PORCH = 10,
    parameter int          V_SYNC_PULSE  = 2,
    parameter int          V_BACK_PORCH  = 33,
    parameter int          SPRITE_W      = 34,
    parameter int          SPRITE_H      = 22,
    parameter int          SCALE_BITS    = 3,
    parameter int          FRAME_BITS    = 1,
    parameter int          FRAME_HOLD    = 16,
    parameter int          PIX_BITS      = 4,
    parameter int          INIT_X        = 128,
    parameter int          INIT_Y        = 128,
    parameter int          VEL_X         = 2,
    parameter int          VEL_Y         = 1,
    parameter logic [5:0]  BG_COLOR      = 6'b000111
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    output logic [FRAME_BITS+$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0]   rom_addr,
    input  logic [PIX_BITS-1:0]                                       rom_data,
    input  logic                                                      pal_we,
    input  logic [PIX_BITS-1:0]                                       pal_addr,
    input  logic [5:0]                                                pal_data,
    output logic                                                      frame_start,
    output logic [7:0]                                                vga_pmod
);
    localparam int H_TOTAL   = H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL   = V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int XW        = $clog2(H_TOTAL);
    localparam int YW        = $clog2(V_TOTAL);
    localparam int CW        = $clog2(SPRITE_W);
    localparam int RW        = $clog2(SPRITE_H);
    localparam int HW        = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int SPR_W_SCR = SPRITE_W << SCALE_BITS;
    localparam int SPR_H_SCR = SPRITE_H << SCALE_BITS;
    localparam int X_LIM     = H_PIXELS - SPR_W_SCR;
    localparam int Y_LIM     = V_PIXELS - SPR_H_SCR;
    localparam int HS_START  = H_PIXELS + H_FRONT_PORCH;
    localparam int VS_START  = V_PIXELS + V_FRONT_PORCH;

    logic [XW-1:0]         x, pos_x, dx;
    logic [YW-1:0]         y, pos_y, dy;
    logic                  dir_x_neg, dir_y_neg;
    logic [FRAME_BITS-1:0] anim_frame;
    logic [HW-1:0]         hold_cnt;
    logic [5:0]            palette [2**PIX_BITS];
    logic [XW:0]           x_up;
    logic [YW:0]           y_up;
    logic                  hit, visible, hs, vs, motion_tick;
    logic [CW-1:0]         col, col_raw;
    logic [RW-1:0]         row;
    logic                  s1_vis, s1_hit, s1_hs, s1_vs;
    logic                  s2_vis, s2_hit, s2_hs, s2_vs;
    logic [5:0]            color;

    // S0: raster counters; frame_start is registered so it lines up with (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (x == XW'(H_TOTAL-1)) && (y == YW'(V_TOTAL-1));
            if (x == XW'(H_TOTAL-1)) begin
                x <= '0;
                y <= (y == YW'(V_TOTAL-1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign motion_tick = (x == '0) && (y == YW'(V_PIXELS));
    assign x_up        = {1'b0, pos_x} + (XW+1)'(VEL_X);
    assign y_up        = {1'b0, pos_y} + (YW+1)'(VEL_Y);

    // Motion and animation advance on the first blanking line, never during active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x      <= XW'(INIT_X);
            pos_y      <= YW'(INIT_Y);
            dir_x_neg  <= 1'b0;
            dir_y_neg  <= 1'b0;
            anim_frame <= '0;
            hold_cnt   <= '0;
        end else if (motion_tick) begin
            if (!dir_x_neg) begin
                if (x_up > (XW+1)'(X_LIM)) begin
                    pos_x     <= XW'(X_LIM);
                    dir_x_neg <= 1'b1;
                end else begin
                    pos_x <= x_up[XW-1:0];
                end
            end else if (pos_x < XW'(VEL_X)) begin
                pos_x     <= '0;
                dir_x_neg <= 1'b0;
            end else begin
                pos_x <= pos_x - XW'(VEL_X);
            end
            if (!dir_y_neg) begin
                if (y_up > (YW+1)'(Y_LIM)) begin
                    pos_y     <= YW'(Y_LIM);
                    dir_y_neg <= 1'b1;
                end else begin
                    pos_y <= y_up[YW-1:0];
                end
            end else if (pos_y < YW'(VEL_Y)) begin
                pos_y     <= '0;
                dir_y_neg <= 1'b0;
            end else begin
                pos_y <= pos_y - YW'(VEL_Y);
            end
            if (hold_cnt == HW'(FRAME_HOLD-1)) begin
                hold_cnt   <= '0;
                anim_frame <= anim_frame + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign dx      = x - pos_x;
    assign dy      = y - pos_y;
    assign hit     = (x >= pos_x) && (dx < XW'(SPR_W_SCR)) && (y >= pos_y) && (dy < YW'(SPR_H_SCR));
    assign visible = (x < XW'(H_PIXELS)) && (y < YW'(V_PIXELS));
    assign hs      = !((x >= XW'(HS_START)) && (x < XW'(HS_START + H_SYNC_PULSE)));
    assign vs      = !((y >= YW'(VS_START)) && (y < YW'(VS_START + V_SYNC_PULSE)));
    assign col_raw = CW'(dx >> SCALE_BITS);
    assign row     = RW'(dy >> SCALE_BITS);
`ifdef SPRITE_MIRROR_EN
    assign col     = dir_x_neg ? CW'(SPRITE_W-1) - col_raw : col_raw;
`else
    assign col     = col_raw;
`endif

    // S2: rom_data arrives from the external ROM; index 0 is transparent
    always_comb begin
        color = 6'b0;
        if (s2_vis) begin
            color = BG_COLOR;
            if (s2_hit && (rom_data != '0)) begin
                color = palette[rom_data];
            end
        end
    end

    // S1 address/flags, S2 flag delay, S3 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            s1_vis   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s2_vis   <= 1'b0;
            s2_hit   <= 1'b0;
            s2_hs    <= 1'b1;
            s2_vs    <= 1'b1;
            vga_pmod <= 8'b1000_1000;
        end else begin
            rom_addr <= hit ? {anim_frame, row, col} : '0;
            s1_vis   <= visible;
            s1_hit   <= hit;
            s1_hs    <= hs;
            s1_vs    <= vs;
            s2_vis   <= s1_vis;
            s2_hit   <= s1_hit;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            vga_pmod <= {s2_hs, color[0], color[2], color[4], s2_vs, color[1], color[3], color[5]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**PIX_BITS; i++) begin
                palette[i] <= 6'b0;
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a shrunken 40x29 raster with a 5x3 sprite scaled x2.
// Pixel (x,y) of frame f shows on vga_pmod during cycle f*1160 + y*40 + x + 3 after reset release.
module tb_vga_sprite_engine;
    localparam int         HT    = 40;
    localparam int         FRAME = 40 * 29;
    localparam logic [7:0] BG    = 8'b1110_1100;
    localparam logic [7:0] RED   = 8'b1001_1001;
    localparam logic [7:0] BLANK = 8'b1000_1000;
`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] rom_addr;
    logic [3:0] rom_data = '0;
    logic [3:0] rom_const = 4'd5;
    logic       pal_we = 1'b0;
    logic [3:0] pal_addr = '0;
    logic [5:0] pal_data = '0;
    logic       frame_start;
    logic [7:0] vga_pmod;
    int         cyc;
    int         n_checks = 0;
    int         n_fail = 0;

    int ex_x [25] = '{4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 22, 20, 18, 16, 14, 12, 10, 8, 6, 4, 2, 0, 0, 2, 4};
    int ex_y [25] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 18, 17, 16, 15, 14, 13, 12, 11, 10, 9};

    vga_sprite_engine #(
        .H_PIXELS(32), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(2),
        .V_PIXELS(24), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
        .SPRITE_W(5), .SPRITE_H(3), .SCALE_BITS(1), .FRAME_BITS(1), .FRAME_HOLD(4),
        .PIX_BITS(4), .INIT_X(4), .INIT_Y(4), .VEL_X(2), .VEL_Y(1), .BG_COLOR(6'b000111)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .frame_start(frame_start), .vga_pmod(vga_pmod)
    );

    // clock, cycle counter since reset release, synchronous sprite ROM
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) rom_data <= rom_const;

    initial begin
        #600000;
        $display("FAIL watchdog: time %0t exceeded, cycle %0d", $time, cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_pix(input int t, input string tag, input logic [7:0] exp);
        at_cycle(t);
        check(tag, {24'd0, vga_pmod}, {24'd0, exp});
    endtask

    task automatic expect_addr(input int t, input string tag, input logic [5:0] exp);
        at_cycle(t);
        check(tag, {26'd0, rom_addr}, {26'd0, exp});
    endtask

    task automatic expect_fs(input int t, input string tag, input logic exp);
        at_cycle(t);
        check(tag, {31'd0, frame_start}, {31'd0, exp});
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [5:0] d);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
        @(negedge clk);
        pal_we   = 1'b0;
    endtask

    initial begin
        int         base, px, py;
        logic       anim, mir;
        logic [7:0] past;

        repeat (3) @(negedge clk);
        check("rst_pmod", {24'd0, vga_pmod}, {24'd0, BLANK});
        check("rst_addr", {26'd0, rom_addr}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        rst_n = 1'b1;

        at_cycle(1);
        pal_write(4'd5, 6'b110000);
        pal_write(4'd3, 6'b101101);

        // frame 0: sync timing and sprite edges at (4,4)
        expect_pix(34, "vis_last_col", BG);
        expect_pix(35, "hblank_first", BLANK);
        expect_pix(36, "hsync_pre", BLANK);
        expect_pix(37, "hsync_first", 8'b0000_1000);
        expect_pix(40, "hsync_last", 8'b0000_1000);
        expect_pix(41, "hsync_post", BLANK);
        expect_pix(4*HT + 3 + 3 - 40, "above_sprite", BG);
        expect_pix(4*HT + 3 + 3, "left_of_sprite", BG);
        expect_pix(4*HT + 4 + 3, "sprite_tl", RED);
        expect_pix(4*HT + 13 + 3, "sprite_right", RED);
        expect_pix(4*HT + 14 + 3, "right_of_sprite", BG);
        expect_pix(9*HT + 4 + 3, "sprite_bottom", RED);
        expect_pix(10*HT + 4 + 3, "below_sprite", BG);
        expect_pix(24*HT + 3, "vblank_line", BLANK);
        expect_pix(25*HT + 3, "vsync_first", 8'b1000_0000);
        expect_pix(26*HT + 35 + 3, "both_sync", 8'b0000_0000);
        expect_pix(27*HT + 3, "vsync_post", BLANK);
        expect_fs(FRAME - 1, "fs_before", 1'b0);
        expect_fs(FRAME, "fs_pulse", 1'b1);
        expect_fs(FRAME + 1, "fs_after", 1'b0);

        // frame 1: index 0 stays transparent even with a non-zero palette entry
        at_cycle(FRAME + 5);
        rom_const = 4'd0;
        pal_write(4'd0, 6'b110000);
        expect_pix(FRAME + 5*HT + 6 + 3, "transp_tl", BG);
        expect_pix(FRAME + 7*HT + 10 + 3, "transp_mid", BG);
        expect_addr(FRAME + 8*HT + 9 + 1, "addr_f1", 6'b001001);
        at_cycle(FRAME + 24*HT + 10);
        rom_const = 4'd3;

        // frame 2: another palette entry checks the bit ordering on the PMOD
        expect_pix(2*FRAME + 6*HT + 7 + 3, "f2_left", BG);
        expect_pix(2*FRAME + 6*HT + 8 + 3, "f2_color", 8'b1110_1011);
        at_cycle(2*FRAME + 24*HT + 20);
        rom_const = 4'd5;

        // frames 3..24: bounce, animation frame field and optional mirroring
        for (int f = 3; f < 25; f++) begin
            base = f * FRAME;
            px   = ex_x[f];
            py   = ex_y[f];
            anim = ((f / 4) % 2) != 0;
            mir  = MIRROR && (f >= 10) && (f <= 21);
            past = (px + 10 < 32) ? BG : BLANK;
            expect_fs(base, $sformatf("fs_f%0d", f), 1'b1);
            expect_pix(base + (py-1)*HT + px + 3, $sformatf("above_f%0d", f), BG);
            expect_addr(base + py*HT + px + 1, $sformatf("addr_tl_f%0d", f), {anim, 2'b00, mir ? 3'd4 : 3'd0});
            if (px > 0) expect_pix(base + py*HT + px + 2, $sformatf("left_f%0d", f), BG);
            expect_pix(base + py*HT + px + 3, $sformatf("tl_f%0d", f), RED);
            expect_addr(base + (py+2)*HT + px + 4, $sformatf("addr_11_f%0d", f), {anim, 2'b01, mir ? 3'd3 : 3'd1});
            expect_pix(base + (py+5)*HT + px + 12, $sformatf("br_f%0d", f), RED);
            expect_pix(base + (py+5)*HT + px + 13, $sformatf("past_br_f%0d", f), past);
        end

        // frame 25 mid-line: asynchronous reset, then a fresh frame with a cleared palette
        expect_pix(25*FRAME + 9*HT + 8 + 3, "pre_rst_pix", RED);
        expect_addr(25*FRAME + 9*HT + 8 + 3, "pre_rst_addr", 6'b000010);
        rst_n = 1'b0;
        #1;
        check("async_rst_pmod", {24'd0, vga_pmod}, {24'd0, BLANK});
        check("async_rst_addr", {26'd0, rom_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_pix(4*HT + 3 + 3, "post_rst_bg", BG);
        expect_pix(4*HT + 4 + 3, "post_rst_pal0", BLANK);
        expect_addr(4*HT + 4 + 3, "post_rst_addr_c1", 6'b000001);
        expect_addr(6*HT + 7 + 1, "post_rst_addr_11", 6'b001001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
